exit_pay_ctrl: RTL and testbench
================================

# exit_pay_ctrl

Exit-booth payment controller placed directly upstream of the car-park occupancy/fee block. On a driver's exit request for an occupied space, it captures that space's running fee, collects coins until the fee is covered, and returns change. It then issues the one-cycle `car_left` pulse that frees the space and holds the exit barrier open. A refund path covers cancel and timeout; only one exit transaction is in progress at a time.

## Interface
- `BAR_HOLD`, default 4: cycles `barrier_open` stays high per paid exit (≥1).
- `TIMEOUT`, default 200: consecutive coin-less COLLECT cycles before automatic refund (≥1, ≤255).
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `exit_req` input 4: per-space exit request (level).
- `occ` input 4: occupancy vector from the car-park block.
- `fee0`..`fee3` input 8 each: running fee per space from the car-park block.
- `coin_valid` input 1: coin inserted this cycle.
- `coin_val` input 8: coin value, qualified by `coin_valid`.
- `cancel` input 1: driver abort.
- `car_left` output 4: one-hot, one-cycle pulse releasing a space.
- `barrier_open` output 1: exit barrier drive.
- `busy` output 1: high in any state other than IDLE.
- `amount_due` output 8: latched fee of current transaction.
- `change_valid` output 1: one-cycle pulse; `change_amt` is valid.
- `change_amt` output 8: change or refund value.
- `refund` output 1: qualifies `change_valid` as a refund (cancel or timeout).
- `coin_reject` output 1: one-cycle pulse, coin arrived outside COLLECT.

## Operation
- States: IDLE, COLLECT, OPEN. All outputs are registered.
- Reset (`rst`=0, asynchronous): state IDLE; `paid`, `amount_due`, timeout counter, hold counter cleared; every output 0.
- IDLE: let eligible = `exit_req & occ`. If nonzero, select the lowest set index `s`, latch `amount_due <= fee[s]`, clear `paid`.
  - If `fee[s]`==0: go directly to OPEN with a zero-change, non-refund `change_valid` pulse.
  - Otherwise go to COLLECT.
  - Requests for unoccupied spaces are ignored.
- The fee is frozen at latch time; later growth of `fee[s]` is ignored.
- COLLECT:
  - Each `coin_valid` adds `coin_val` into 9-bit `paid` and reloads the timeout counter.
  - If the new sum ≥ `amount_due`: go to OPEN, `change_amt` = sum − `amount_due` (always <256), `change_valid`=1, `refund`=0.
  - `cancel`, or timeout counter reaching `TIMEOUT`: go to IDLE, `change_amt` = `paid` (including any same-cycle coin), `change_valid`=1, `refund`=1, no `car_left`. `cancel` takes priority over a completing coin in the same cycle.
- OPEN:
  - `car_left[s]` pulses in the first OPEN cycle only.
  - `barrier_open` is high for exactly `BAR_HOLD` cycles, then the block returns to IDLE.
- `coin_valid` in IDLE or OPEN: the coin is not added; `coin_reject` pulses the next cycle.
- `exit_req` and `cancel` are ignored outside the states where they are listed.

## Timing
- Request sampled at edge T → `busy` and `amount_due` valid from T+1.
- Completing coin sampled at edge T → `car_left`, `change_valid`, and `barrier_open` high in cycle T+1.
- `barrier_open` falls at T+1+`BAR_HOLD`; the earliest next request is sampled that same edge.
- Zero-fee request at T → `car_left` in cycle T+1.
- Cancel/timeout at edge T → refund pulse and `busy`=0 in cycle T+1.
- Timeout: `TIMEOUT` consecutive COLLECT cycles with no coin.
- `rst` asserted mid-transaction: the in-progress payment is lost, with no refund or `car_left` pulse.

## Test plan
- Reset with all inputs toggling → all outputs 0, `busy`=0. Release, then `occ`=0001, `fee0`=30, `exit_req`=0001 → `amount_due`=30. Coins 20 then 20 → one cycle later `car_left`=0001, `change_amt`=10, `change_valid`=1, `refund`=0, `barrier_open` high for 4 cycles.
- `occ`=0110, `exit_req`=0111 → space 1 selected, `car_left`=0010. Request for space 0 alone with `occ[0]`=0 → stays IDLE.
- Due 50, coin 20, then `cancel` with coin 40 in the same cycle → `refund`=1, `change_amt`=60, no `car_left`, IDLE.
- Due 10, coin 5, then 200 idle cycles → refund 5 exactly at the timeout cycle. A coin at cycle 199 reloads the counter instead.
- `fee2`=0 with `exit_req`=0100 → `car_left`=0100 next cycle, `change_amt`=0. Coin during OPEN → `coin_reject` pulse, paid unchanged.
- Due 255, single coin 255 → change 0. Due 1, coin 255 → change 254 (9-bit sum, no overflow).

Source files
------------

// File: rtl/exit_pay_ctrl.sv
// Exit-booth payment controller: latches the fee of the requesting space, collects
// coins, returns change or a refund, then releases the space and holds the barrier open.
module exit_pay_ctrl #(
    parameter int unsigned BAR_HOLD = 4,
    parameter int unsigned TIMEOUT  = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] exit_req,
    input  logic [3:0] occ,
    input  logic [7:0] fee0,
    input  logic [7:0] fee1,
    input  logic [7:0] fee2,
    input  logic [7:0] fee3,
    input  logic       coin_valid,
    input  logic [7:0] coin_val,
    input  logic       cancel,
    output logic [3:0] car_left,
    output logic       barrier_open,
    output logic       busy,
    output logic [7:0] amount_due,
    output logic       change_valid,
    output logic [7:0] change_amt,
    output logic       refund,
    output logic       coin_reject
);

    localparam int unsigned HW = (BAR_HOLD < 2) ? 1 : $clog2(BAR_HOLD + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(BAR_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(1);
    localparam logic [8:0]    TMO_LIM   = 9'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, COLLECT, OPEN} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [7:0]    due_q, due_d;
    logic [8:0]    paid_q, paid_d;
    logic [7:0]    tmo_q, tmo_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    car_left_q, car_left_d;
    logic          barrier_q, barrier_d;
    logic          busy_q;
    logic          chg_v_q, chg_v_d;
    logic [7:0]    chg_amt_q, chg_amt_d;
    logic          refund_q, refund_d;
    logic          reject_q, reject_d;

    logic [7:0] fee_arr [4];
    logic [3:0] eligible;
    logic [1:0] sel_idx;
    logic       found;
    logic       try_start;
    logic [8:0] coin_sum;

    always_comb begin
        fee_arr[0] = fee0;
        fee_arr[1] = fee1;
        fee_arr[2] = fee2;
        fee_arr[3] = fee3;
        eligible   = exit_req & occ;
        sel_idx    = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (eligible[i] && !found) begin
                sel_idx = 2'(i);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        due_d      = due_q;
        paid_d     = paid_q;
        tmo_d      = tmo_q;
        hold_d     = hold_q;
        car_left_d = '0;
        barrier_d  = 1'b0;
        chg_v_d    = 1'b0;
        chg_amt_d  = chg_amt_q;
        refund_d   = 1'b0;
        reject_d   = 1'b0;
        try_start  = 1'b0;
        coin_sum   = paid_q + {1'b0, coin_val};

        unique case (state_q)
            IDLE: begin
                reject_d  = coin_valid;
                try_start = 1'b1;
            end
            COLLECT: begin
                if (cancel || (!coin_valid && ({1'b0, tmo_q} + 9'd1 == TMO_LIM))) begin
                    state_d   = IDLE;
                    chg_v_d   = 1'b1;
                    refund_d  = 1'b1;
                    chg_amt_d = coin_valid ? coin_sum[7:0] : paid_q[7:0];
                end else if (coin_valid) begin
                    paid_d = coin_sum;
                    tmo_d  = '0;
                    if (coin_sum >= {1'b0, due_q}) begin
                        state_d    = OPEN;
                        chg_v_d    = 1'b1;
                        chg_amt_d  = 8'(coin_sum - {1'b0, due_q});
                        car_left_d = 4'(1) << sel_q;
                        barrier_d  = 1'b1;
                        hold_d     = HOLD_INIT;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            OPEN: begin
                reject_d = coin_valid;
                if (hold_q == HOLD_LAST) begin
                    // Last barrier cycle doubles as IDLE so a waiting request is taken on the falling edge.
                    state_d   = IDLE;
                    try_start = 1'b1;
                end else begin
                    barrier_d = 1'b1;
                    hold_d    = hold_q - HOLD_LAST;
                end
            end
            default: state_d = IDLE;
        endcase

        if (try_start && found) begin
            sel_d  = sel_idx;
            due_d  = fee_arr[sel_idx];
            paid_d = '0;
            tmo_d  = '0;
            if (fee_arr[sel_idx] == 8'd0) begin
                state_d    = OPEN;
                chg_v_d    = 1'b1;
                chg_amt_d  = '0;
                car_left_d = 4'(1) << sel_idx;
                barrier_d  = 1'b1;
                hold_d     = HOLD_INIT;
            end else begin
                state_d = COLLECT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            due_q      <= '0;
            paid_q     <= '0;
            tmo_q      <= '0;
            hold_q     <= '0;
            car_left_q <= '0;
            barrier_q  <= 1'b0;
            busy_q     <= 1'b0;
            chg_v_q    <= 1'b0;
            chg_amt_q  <= '0;
            refund_q   <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            due_q      <= due_d;
            paid_q     <= paid_d;
            tmo_q      <= tmo_d;
            hold_q     <= hold_d;
            car_left_q <= car_left_d;
            barrier_q  <= barrier_d;
            busy_q     <= (state_d != IDLE);
            chg_v_q    <= chg_v_d;
            chg_amt_q  <= chg_amt_d;
            refund_q   <= refund_d;
            reject_q   <= reject_d;
        end
    end

    assign car_left     = car_left_q;
    assign barrier_open = barrier_q;
    assign busy         = busy_q;
    assign amount_due   = due_q;
    assign change_valid = chg_v_q;
    assign change_amt   = chg_amt_q;
    assign refund       = refund_q;
    assign coin_reject  = reject_q;

endmodule

// File: tb/tb_exit_pay_ctrl.sv
// Directed bench for exit_pay_ctrl: vector table for the main flow, hand sequences
// for cancel, timeout, 9-bit sums, back-to-back exits and mid-transaction reset.
module tb_exit_pay_ctrl;

    logic       clk, rst;
    logic [3:0] exit_req, occ;
    logic [7:0] fee0, fee1, fee2, fee3;
    logic       coin_valid;
    logic [7:0] coin_val;
    logic       cancel;
    logic [3:0] car_left;
    logic       barrier_open, busy, change_valid, refund, coin_reject;
    logic [7:0] amount_due, change_amt;

    int checks = 0;
    int errors = 0;

    exit_pay_ctrl #(.BAR_HOLD(4), .TIMEOUT(200)) dut (
        .clk(clk), .rst(rst), .exit_req(exit_req), .occ(occ),
        .fee0(fee0), .fee1(fee1), .fee2(fee2), .fee3(fee3),
        .coin_valid(coin_valid), .coin_val(coin_val), .cancel(cancel),
        .car_left(car_left), .barrier_open(barrier_open), .busy(busy),
        .amount_due(amount_due), .change_valid(change_valid), .change_amt(change_amt),
        .refund(refund), .coin_reject(coin_reject)
    );

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] occ;
        logic       cv;
        logic [7:0] cval;
        logic       can;
        logic [3:0] e_cl;
        logic       e_bar;
        logic       e_busy;
        logic [7:0] e_due;
        logic       e_chv;
        logic [7:0] e_amt;
        logic       e_ref;
        logic       e_rej;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic [3:0] req, input logic [3:0] oc, input logic cv,
                               input logic [7:0] cval, input logic can, input logic [3:0] cl,
                               input logic bar, input logic bsy, input logic [7:0] due,
                               input logic chv, input logic [7:0] amt, input logic rf,
                               input logic rj);
        vec_t r;
        r.req = req; r.occ = oc; r.cv = cv; r.cval = cval; r.can = can;
        r.e_cl = cl; r.e_bar = bar; r.e_busy = bsy; r.e_due = due;
        r.e_chv = chv; r.e_amt = amt; r.e_ref = rf; r.e_rej = rj;
        return r;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic coin(input logic [7:0] val);
        coin_valid = 1'b1;
        coin_val   = val;
        tick();
        coin_valid = 1'b0;
        coin_val   = '0;
    endtask

    task automatic request(input logic [3:0] r);
        exit_req = r;
        tick();
        exit_req = '0;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({car_left, barrier_open, busy, amount_due, change_valid, change_amt,
                    refund, coin_reject});
    endfunction

    initial begin
        int early;
        rst = 1'b0;
        exit_req = '0; occ = '0; coin_valid = 1'b0; coin_val = '0; cancel = 1'b0;
        fee0 = 8'd30; fee1 = 8'd40; fee2 = 8'd0; fee3 = 8'd7;

        // reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            exit_req = ~exit_req; occ = ~occ; coin_valid = ~coin_valid;
            coin_val = coin_val + 8'd77; cancel = ~cancel;
            tick();
            chk($sformatf("reset_outputs_%0d", i), all_outs(), 32'd0);
        end
        exit_req = '0; occ = '0; coin_valid = 1'b0; coin_val = '0; cancel = 1'b0;
        rst = 1'b1;
        tick();

        //        req    occ    cv  cval  can  cl     bar  busy due    chv amt    ref rej
        vecs.push_back(v(4'h0, 4'h0, 0, 8'd0, 0, 4'h0, 0, 0, 8'd0, 0, 8'd0, 0, 0));
        vecs.push_back(v(4'h1, 4'h1, 0, 8'd0, 0, 4'h0, 0, 1, 8'd30, 0, 8'd0, 0, 0));
        vecs.push_back(v(4'h0, 4'h1, 1, 8'd20, 0, 4'h0, 0, 1, 8'd30, 0, 8'd0, 0, 0));
        vecs.push_back(v(4'h0, 4'h1, 1, 8'd20, 0, 4'h1, 1, 1, 8'd30, 1, 8'd10, 0, 0));
        vecs.push_back(v(4'h0, 4'h1, 0, 8'd0, 0, 4'h0, 1, 1, 8'd30, 0, 8'd0, 0, 0));
        vecs.push_back(v(4'h0, 4'h1, 0, 8'd0, 0, 4'h0, 1, 1, 8'd30, 0, 8'd0, 0, 0));
        vecs.push_back(v(4'h0, 4'h1, 0, 8'd0, 0, 4'h0, 1, 1, 8'd30, 0, 8'd0, 0, 0));
        vecs.push_back(v(4'h0, 4'h1, 0, 8'd0, 0, 4'h0, 0, 0, 8'd30, 0, 8'd0, 0, 0));
        vecs.push_back(v(4'h7, 4'h6, 0, 8'd0, 0, 4'h0, 0, 1, 8'd40, 0, 8'd0, 0, 0));
        vecs.push_back(v(4'h0, 4'h6, 1, 8'd50, 0, 4'h2, 1, 1, 8'd40, 1, 8'd10, 0, 0));
        vecs.push_back(v(4'h0, 4'h6, 0, 8'd0, 0, 4'h0, 1, 1, 8'd40, 0, 8'd0, 0, 0));
        vecs.push_back(v(4'h0, 4'h6, 0, 8'd0, 0, 4'h0, 1, 1, 8'd40, 0, 8'd0, 0, 0));
        vecs.push_back(v(4'h0, 4'h6, 0, 8'd0, 0, 4'h0, 1, 1, 8'd40, 0, 8'd0, 0, 0));
        vecs.push_back(v(4'h0, 4'h6, 0, 8'd0, 0, 4'h0, 0, 0, 8'd40, 0, 8'd0, 0, 0));
        vecs.push_back(v(4'h1, 4'h6, 0, 8'd0, 0, 4'h0, 0, 0, 8'd40, 0, 8'd0, 0, 0));
        vecs.push_back(v(4'h4, 4'h4, 0, 8'd0, 0, 4'h4, 1, 1, 8'd0, 1, 8'd0, 0, 0));
        vecs.push_back(v(4'h0, 4'h4, 1, 8'd9, 0, 4'h0, 1, 1, 8'd0, 0, 8'd0, 0, 1));
        vecs.push_back(v(4'h0, 4'h4, 0, 8'd0, 0, 4'h0, 1, 1, 8'd0, 0, 8'd0, 0, 0));
        vecs.push_back(v(4'h0, 4'h4, 0, 8'd0, 0, 4'h0, 1, 1, 8'd0, 0, 8'd0, 0, 0));
        vecs.push_back(v(4'h0, 4'h4, 0, 8'd0, 0, 4'h0, 0, 0, 8'd0, 0, 8'd0, 0, 0));
        vecs.push_back(v(4'h0, 4'h0, 1, 8'd9, 0, 4'h0, 0, 0, 8'd0, 0, 8'd0, 0, 1));
        vecs.push_back(v(4'h0, 4'h0, 0, 8'd0, 0, 4'h0, 0, 0, 8'd0, 0, 8'd0, 0, 0));

        foreach (vecs[i]) begin
            exit_req = vecs[i].req; occ = vecs[i].occ; coin_valid = vecs[i].cv;
            coin_val = vecs[i].cval; cancel = vecs[i].can;
            tick();
            chk($sformatf("vec%0d_car_left", i), 32'(car_left), 32'(vecs[i].e_cl));
            chk($sformatf("vec%0d_barrier", i), 32'(barrier_open), 32'(vecs[i].e_bar));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_amount_due", i), 32'(amount_due), 32'(vecs[i].e_due));
            chk($sformatf("vec%0d_change_valid", i), 32'(change_valid), 32'(vecs[i].e_chv));
            if (vecs[i].e_chv)
                chk($sformatf("vec%0d_change_amt", i), 32'(change_amt), 32'(vecs[i].e_amt));
            chk($sformatf("vec%0d_refund", i), 32'(refund), 32'(vecs[i].e_ref));
            chk($sformatf("vec%0d_coin_reject", i), 32'(coin_reject), 32'(vecs[i].e_rej));
        end
        exit_req = '0; coin_valid = 1'b0; coin_val = '0; cancel = 1'b0;
        occ = 4'h1;

        // cancel beats a completing coin; fee frozen at latch time
        fee0 = 8'd50;
        request(4'h1);
        chk("cancel_due", 32'(amount_due), 32'd50);
        fee0 = 8'd90;
        coin(8'd20);
        chk("fee_frozen", 32'(amount_due), 32'd50);
        chk("cancel_no_early_change", 32'(change_valid), 32'd0);
        cancel = 1'b1;
        coin(8'd40);
        cancel = 1'b0;
        chk("cancel_change_valid", 32'(change_valid), 32'd1);
        chk("cancel_refund", 32'(refund), 32'd1);
        chk("cancel_amt", 32'(change_amt), 32'd60);
        chk("cancel_car_left", 32'(car_left), 32'd0);
        chk("cancel_busy", 32'(busy), 32'd0);
        chk("cancel_barrier", 32'(barrier_open), 32'd0);
        tick();
        chk("cancel_pulse_one_cycle", 32'(change_valid), 32'd0);

        // timeout: coin at the 199th idle cycle reloads, then exactly 200 idle cycles refund
        fee0 = 8'd10;
        request(4'h1);
        coin(8'd5);
        early = 0;
        repeat (198) begin
            tick();
            if (change_valid || !busy) early++;
        end
        coin(8'd1);
        if (change_valid || !busy) early++;
        repeat (199) begin
            tick();
            if (change_valid || !busy) early++;
        end
        chk("timeout_not_early", 32'(early), 32'd0);
        tick();
        chk("timeout_change_valid", 32'(change_valid), 32'd1);
        chk("timeout_refund", 32'(refund), 32'd1);
        chk("timeout_amt", 32'(change_amt), 32'd6);
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("timeout_car_left", 32'(car_left), 32'd0);

        // 255 due with 255 coin, then a request taken on the barrier-falling edge
        fee0 = 8'd255;
        request(4'h1);
        coin(8'd255);
        chk("max_car_left", 32'(car_left), 32'd1);
        chk("max_change_valid", 32'(change_valid), 32'd1);
        chk("max_amt", 32'(change_amt), 32'd0);
        chk("max_refund", 32'(refund), 32'd0);
        repeat (3) tick();
        chk("max_barrier_last", 32'(barrier_open), 32'd1);
        fee0 = 8'd1;
        request(4'h1);
        chk("b2b_barrier_fall", 32'(barrier_open), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_due", 32'(amount_due), 32'd1);
        coin(8'd255);
        chk("wide_car_left", 32'(car_left), 32'd1);
        chk("wide_change_valid", 32'(change_valid), 32'd1);
        chk("wide_amt", 32'(change_amt), 32'd254);
        repeat (4) tick();
        chk("wide_done_busy", 32'(busy), 32'd0);

        // reset mid-transaction loses the payment silently
        fee0 = 8'd30;
        request(4'h1);
        coin(8'd20);
        #2 rst = 1'b0;
        #1 chk("async_reset_outputs", all_outs(), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_pulses", 32'({car_left, change_valid}), 32'd0);
        request(4'h1);
        coin(8'd20);
        chk("paid_cleared_no_change", 32'(change_valid), 32'd0);
        chk("paid_cleared_busy", 32'(busy), 32'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("paid_cleared_refund", 32'(refund), 32'd1);
        chk("paid_cleared_amt", 32'(change_amt), 32'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
